alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, 8, operand/result width; SHALL match the shared ALU data width.
REQ-002 Parameter: OPW, 4, opcode width; SHALL match the shared ALU opcode width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester request accept.
REQ-007 req_opcode  input  2*OPW  per-requester opcode; requester i uses bits [i*OPW +: OPW].
REQ-008 req_a  input  2*DW  per-requester operand A, packed the same way.
REQ-009 req_b  input  2*DW  per-requester operand B, packed the same way.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_result  output  DW  captured ALU result, shared by both requesters and qualified by rsp_valid.
REQ-013 rsp_flags  output  3  captured {Negative, Carry, Zero}.
REQ-014 alu_opcode  output  OPW  opcode driven to the shared ALU.
REQ-015 alu_a  output  DW  operand A driven to the shared ALU.
REQ-016 alu_b  output  DW  operand B driven to the shared ALU.
REQ-017 alu_result  input  DW  combinational result from the shared ALU.
REQ-018 alu_zero, alu_carry, alu_negative  input  1 each  combinational flags from the shared ALU.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 grant_id  output  1  index of the requester currently owning the ALU; valid while busy.
REQ-021 op_count  output  16  number of completed response handshakes.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-023 IDLE: when any req_valid bit is set, the block SHALL select one winner, assert req_ready for the winner only (combinational, same cycle), register the winner's opcode and operands plus grant_id, and move to EXEC.
REQ-024 req_ready SHALL be 0 in EXEC and RESP, and 0 for the loser of arbitration.
REQ-025 EXEC: alu_opcode, alu_a and alu_b SHALL come from the registered values; the ALU outputs SHALL be captured into rsp_result and rsp_flags at the end of the cycle; the FSM SHALL then move to RESP.
REQ-026 Outside EXEC, alu_opcode, alu_a and alu_b SHALL hold their last registered values (no glitching toward requester inputs).
REQ-027 RESP: rsp_valid[grant_id] SHALL be 1 and the other bit 0; rsp_result and rsp_flags SHALL stay stable until the handshake.
REQ-028 In RESP, rsp_ready[grant_id]=1 SHALL complete the transaction: op_count increments and the FSM returns to IDLE; rsp_ready on the non-granted bit SHALL be ignored.
REQ-029 Latency: with rsp_ready held high, the accept happens in cycle N, rsp_valid rises in cycle N+2, and the next accept can happen no earlier than cycle N+3.
REQ-030 A stalled response (rsp_ready low) SHALL hold RESP indefinitely; a new request SHALL NOT be accepted during the stall.
REQ-031 Opcodes the ALU does not define (values 5..15) SHALL be passed through unchanged; the response SHALL carry whatever the ALU returns (Result 0, Zero 1).
REQ-032 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-033 Arbitration: if only one req_valid bit is set, that requester SHALL win; if both are set, the winner follows REQ-038/REQ-039.

Reset
REQ-034 When rst is high at a clock edge, the next state SHALL be: IDLE, req_ready=0, rsp_valid=0, busy=0, grant_id=0, op_count=0, rsp_result=0, rsp_flags=0, alu_opcode/alu_a/alu_b=0, and the priority pointer set to requester 0.
REQ-035 Reset asserted in EXEC or RESP SHALL drop the in-flight transaction with no response issued.
REQ-036 During the cycle rst is high, req_ready SHALL be 0.

Configuration
REQ-037 The macro ALU_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-038 With ALU_ARBITER_RR_EN defined, round-robin: on a tie, the requester not served by the last completed transaction SHALL win; the pointer SHALL update only on response handshake.
REQ-039 With ALU_ARBITER_RR_EN undefined, fixed priority: requester 0 SHALL always win ties, and there SHALL be no pointer state.

Verification
REQ-040 Single op: requester 0 sends ADD A=0xF0, B=0x20 with rsp_ready=1 -> rsp_valid[0] two cycles after accept, rsp_result=0x10, flags {N,C,Z}=010, op_count=1.
REQ-041 Tie, RR_EN defined: both requesters valid continuously (r0 SUB 5-5, r1 XOR 0xAA^0xFF) -> grants alternate 0,1,0,1; r0 gets result 0x00 with Z=1; r1 gets 0x55.
REQ-042 Tie, RR_EN undefined: same stimulus as REQ-041 -> requester 0 served every time and requester 1 is starved.
REQ-043 Backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP -> result and flags stable, req_ready stays 0; release -> one handshake and op_count increments once.
REQ-044 Reset mid-op: assert rst in EXEC -> no rsp_valid pulse, all outputs equal their REQ-034 values, and a new request is accepted on the first cycle after rst deasserts.
REQ-045 Illegal opcode / wrap: opcode 0x9 -> result 0x00 with Z=1; preload 0xFFFF completions then one more -> op_count=0x0000.

Source files
------------

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter
// Shares one combinational ALU between two requesters. A three-state FSM
// (IDLE -> EXEC -> RESP) accepts one request, presents its registered
// opcode/operands to the ALU for one cycle, captures result and flags, and
// holds the response until the granted requester accepts it.
//
// Configuration macro: ALU_ARBITER_RR_EN
//   defined   -> round-robin tie-break; the pointer moves only on a response
//                handshake and favours the requester not served last.
//   undefined -> fixed priority, requester 0 wins ties, no pointer state.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready [1:0]     per-requester request handshake
//   req_opcode [2*OPW-1:0]        requester i opcode at [i*OPW +: OPW]
//   req_a, req_b [2*DW-1:0]       requester i operands at [i*DW +: DW]
//   rsp_valid/rsp_ready [1:0]     per-requester response handshake
//   rsp_result [DW-1:0]           captured ALU result
//   rsp_flags [2:0]               captured {negative, carry, zero}
//   alu_opcode, alu_a, alu_b      registered operands to the shared ALU
//   alu_result, alu_zero,
//   alu_carry, alu_negative       combinational ALU outputs
//   busy                          high whenever the FSM is not IDLE
//   grant_id                      requester owning the ALU
//   op_count [15:0]               completed response handshakes (wraps)
module alu_arbiter #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*OPW-1:0] req_opcode,
    input  logic [2*DW-1:0]  req_a,
    input  logic [2*DW-1:0]  req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [DW-1:0]    rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [OPW-1:0]   alu_opcode,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_negative,
    output logic             busy,
    output logic             grant_id,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_reg;
    logic           grant_reg;
    logic [OPW-1:0] opcode_reg;
    logic [DW-1:0]  a_reg;
    logic [DW-1:0]  b_reg;
    logic [DW-1:0]  result_reg;
    logic [2:0]     flags_reg;
    logic [15:0]    op_count_reg;

    logic [OPW-1:0] opcode_arr [2];
    logic [DW-1:0]  a_arr [2];
    logic [DW-1:0]  b_arr [2];

    logic winner;
    logic accept;
    logic handshake;

    // Requests are only taken in IDLE and never while reset is asserted.
    assign accept    = !rst && (state_reg == IDLE) && (|req_valid);
    assign handshake = (state_reg == RESP) && rsp_ready[grant_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign opcode_arr[gi] = req_opcode[gi*OPW +: OPW];
            assign a_arr[gi]      = req_a[gi*DW +: DW];
            assign b_arr[gi]      = req_b[gi*DW +: DW];
            assign req_ready[gi]  = accept && (winner == 1'(gi));
            assign rsp_valid[gi]  = (state_reg == RESP) && (grant_reg == 1'(gi));
        end
    endgenerate

`ifdef ALU_ARBITER_RR_EN
    // Requester favoured on a tie; after a completion it points at the
    // requester that was not just served.
    logic prio_reg;

    always_comb begin
        winner = req_valid[1] & ~req_valid[0];
        if (req_valid == 2'b11) begin
            winner = prio_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else if (handshake) begin
            prio_reg <= ~grant_reg;
        end
    end
`else
    // Requester 1 only wins when requester 0 is idle.
    assign winner = ~req_valid[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b0;
            opcode_reg   <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            flags_reg    <= '0;
            op_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        grant_reg  <= winner;
                        opcode_reg <= opcode_arr[winner];
                        a_reg      <= a_arr[winner];
                        b_reg      <= b_arr[winner];
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= alu_result;
                    flags_reg  <= {alu_negative, alu_carry, alu_zero};
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (handshake) begin
                        op_count_reg <= op_count_reg + 16'd1;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ALU operands come straight from registers so they never follow the
    // requester inputs between operations.
    assign alu_opcode = opcode_reg;
    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
    assign rsp_result = result_reg;
    assign rsp_flags  = flags_reg;
    assign busy       = (state_reg != IDLE);
    assign grant_id   = grant_reg;
    assign op_count   = op_count_reg;

endmodule
